// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared types and defaults for the div_sched clock divider.
// Holds the FSM state enum and the default widths used by div_sched and rr_arb.
package div_sched_pkg;

    localparam int DIV_W_DEF = 32;
    localparam int NREQ_DEF  = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PEND
    } state_t;

endpackage

// File: rtl/div_sched_rr_arb.sv
// rr_arb: round-robin arbiter; searches requesters from the pointer upward.
// Ports: clk, rst_n (async, active-low), req, enable -> gnt (one-hot, combinational).
module rr_arb
    import div_sched_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    output logic [NREQ-1:0] gnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_ptr_nxt;
    logic [NREQ-1:0] w_gnt;
    logic            w_found;
    int              w_sel;
    int              w_best;
    int              w_dist;

    // Pick the requester with the smallest distance above the pointer.
    always_comb begin
        w_found   = 1'b0;
        w_sel     = 0;
        w_best    = NREQ;
        w_dist    = 0;
        w_gnt     = '0;
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                w_dist = (i >= int'(r_ptr)) ? (i - int'(r_ptr))
                                            : (i + NREQ - int'(r_ptr));
                if (w_dist < w_best) begin
                    w_best  = w_dist;
                    w_sel   = i;
                    w_found = 1'b1;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            w_gnt[i] = enable && w_found && (i == w_sel);
        end
        if (enable && w_found) begin
            w_ptr_nxt = (w_sel == NREQ - 1) ? '0 : PW'(w_sel + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (|w_gnt) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    assign gnt = w_gnt;

endmodule

// File: rtl/div_sched.sv
// div_sched: shared programmable clock divider; requesters load divide values
// through a round-robin arbiter, new values take effect at a period boundary.
// Ports: clk, rst_n, req_valid/req_div/req_ready (load handshake), tick,
// new_clk, busy, active_div; tick_count only when DIV_SCHED_STAT_EN is defined.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF,
    parameter int NREQ  = NREQ_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ-1:0][DIV_W-1:0] req_div,
    output logic [NREQ-1:0]            req_ready,
    output logic                       tick,
    output logic                       new_clk,
    output logic                       busy,
    output logic [DIV_W-1:0]           active_div
`ifdef DIV_SCHED_STAT_EN
    ,
    output logic [31:0]                tick_count
`endif
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] r_act;
    logic [DIV_W-1:0] w_act_nxt;
    logic [DIV_W-1:0] r_pend;
    logic [DIV_W-1:0] w_pend_nxt;
    logic             r_nclk;
    logic             w_nclk_nxt;
    logic [NREQ-1:0]  w_gnt;
    logic [DIV_W-1:0] w_sel_div;
    logic             w_bound;
    logic             w_arb_en;

    // rst_n gates the grant so req_ready is 0 while reset is held.
    assign w_arb_en = rst_n && (r_state != S_PEND);

    rr_arb #(.NREQ(NREQ)) u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .enable (w_arb_en),
        .gnt    (w_gnt)
    );

    always_comb begin
        w_sel_div = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_div = w_sel_div | req_div[i];
            end
        end
    end

    assign w_bound = (r_state != S_IDLE) && (r_cnt == r_act - DIV_W'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_act_nxt   = r_act;
        w_pend_nxt  = r_pend;
        w_nclk_nxt  = r_nclk;
        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt  = '0;
                w_nclk_nxt = 1'b0;
                if (|w_gnt) begin
                    w_act_nxt   = w_sel_div;
                    w_state_nxt = (w_sel_div != '0) ? S_RUN : S_IDLE;
                end
            end
            S_RUN: begin
                w_cnt_nxt = w_bound ? '0 : r_cnt + DIV_W'(1);
                if (w_bound) begin
                    w_nclk_nxt = ~r_nclk;
                end
                if (|w_gnt) begin
                    w_pend_nxt  = w_sel_div;
                    w_state_nxt = S_PEND;
                end
            end
            S_PEND: begin
                w_cnt_nxt = w_bound ? '0 : r_cnt + DIV_W'(1);
                if (w_bound) begin
                    w_act_nxt = r_pend;
                    if (r_pend == '0) begin
                        w_state_nxt = S_IDLE;
                        w_nclk_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_nclk_nxt  = ~r_nclk;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_act   <= '0;
            r_pend  <= '0;
            r_nclk  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_act   <= w_act_nxt;
            r_pend  <= w_pend_nxt;
            r_nclk  <= w_nclk_nxt;
        end
    end

`ifdef DIV_SCHED_STAT_EN
    logic [31:0] r_tick_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_count <= '0;
        end else if (w_bound) begin
            r_tick_count <= r_tick_count + 32'd1;
        end
    end

    assign tick_count = r_tick_count;
`endif

    assign req_ready  = w_gnt;
    assign tick       = w_bound;
    assign new_clk    = r_nclk;
    assign busy       = (r_state == S_PEND);
    assign active_div = r_act;

endmodule

// File: tb/tb_div_sched.sv
// tb_div_sched: directed self-checking bench for div_sched.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_div_sched;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = '0;
    logic [1:0][31:0] req_div = '0;
    logic [1:0]      req_ready;
    logic            tick;
    logic            new_clk;
    logic            busy;
    logic [31:0]     active_div;
`ifdef DIV_SCHED_STAT_EN
    logic [31:0]     tick_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [36:0] obs;
    logic [36:0] exp_v;
    assign obs = {req_ready, tick, new_clk, busy, active_div};

    div_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_div    (req_div),
        .req_ready  (req_ready),
        .tick       (tick),
        .new_clk    (new_clk),
        .busy       (busy),
        .active_div (active_div)
`ifdef DIV_SCHED_STAT_EN
        ,
        .tick_count (tick_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_div[0] = 32'd5;
        #3;
        n_vec++;
        if (obs !== 37'd0) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", obs, 37'd0);
        end
`ifdef DIV_SCHED_STAT_EN
        n_vec++;
        if (tick_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_tc: got %h want 0", tick_count);
        end
`endif
        next_cyc();
        rst_n = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_vec++;
            if (obs !== 37'd0) begin
                n_err++;
                $display("FAIL idle_after_reset[%0d]: got %h want 0", k, obs);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        req_valid = 2'b01;
        req_div[0] = 32'd3;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL basic_grant: got %b want 01", req_ready);
        end
        next_cyc();
        req_valid = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            exp_v = {2'b00, (k % 3 == 2), ((k / 3) % 2 == 1), 1'b0, 32'd3};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL basic_k%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_rr();
        int g[$];
        do_reset();
        req_valid = 2'b11;
        req_div[0] = 32'd2;
        req_div[1] = 32'd4;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_vec++;
            if ($countones(req_ready) > 1) begin
                n_err++;
                $display("FAIL rr_onehot[%0d]: got %b want <=1 hot", c, req_ready);
            end
            if (req_ready != 2'b00) g.push_back(req_ready[1] ? 1 : 0);
            next_cyc();
        end
        req_valid = '0;
        n_vec++;
        if (g.size() < 4) begin
            n_err++;
            $display("FAIL rr_count: got %0d want >=4", g.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (g[i] !== i % 2) begin
                    n_err++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", i, g[i], i % 2);
                end
            end
        end
    endtask

    task automatic test_pend();
        do_reset();
        req_valid = 2'b01;
        req_div[0] = 32'd5;
        @(negedge clk);
        next_cyc();
        req_valid = '0;
        next_cyc();
        req_valid = 2'b10;
        req_div[1] = 32'd2;
        @(negedge clk);
        exp_v = {2'b10, 1'b0, 1'b0, 1'b0, 32'd5};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL pend_grant: got %h want %h", obs, exp_v);
        end
        next_cyc();
        req_valid = '0;
        for (int k = 2; k < 10; k++) begin
            @(negedge clk);
            exp_v = {2'b00, (k == 4 || k == 6 || k == 8),
                     (k == 5 || k == 6 || k == 9), (k <= 4),
                     (k <= 4) ? 32'd5 : 32'd2};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL pend_k%0d: got %h want %h", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_zero();
        do_reset();
        req_valid = 2'b01;
        req_div[0] = 32'd4;
        @(negedge clk);
        next_cyc();
        req_div[1] = 32'd0;
        for (int k = 0; k < 21; k++) begin
            req_valid = (k == 9) ? 2'b10 : 2'b00;
            @(negedge clk);
            if (k <= 11)
                exp_v = {(k == 9) ? 2'b10 : 2'b00, (k % 4 == 3),
                         (k >= 4 && k <= 7), (k == 10 || k == 11), 32'd4};
            else
                exp_v = 37'd0;
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL zero_k%0d: got %h want %h", k, obs, exp_v);
            end
            next_cyc();
        end
        req_valid = '0;
    endtask

    task automatic test_reset_pend();
        do_reset();
        req_valid = 2'b01;
        req_div[0] = 32'd8;
        @(negedge clk);
        next_cyc();
        req_valid = '0;
        next_cyc();
        req_valid = 2'b10;
        req_div[1] = 32'd3;
        @(negedge clk);
        next_cyc();
        req_valid = '0;
        @(negedge clk);
        exp_v = {2'b00, 1'b0, 1'b0, 1'b1, 32'd8};
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL rstp_pend: got %h want %h", obs, exp_v);
        end
        #2;
        rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        n_vec++;
        if (obs !== 37'd0) begin
            n_err++;
            $display("FAIL rstp_async: got %h want 0", obs);
        end
        next_cyc();
        rst_n = 1'b1;
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_vec++;
            if (obs !== 37'd0) begin
                n_err++;
                $display("FAIL rstp_idle[%0d]: got %h want 0", k, obs);
            end
        end
        next_cyc();
        req_valid = 2'b11;
        req_div[0] = 32'd2;
        req_div[1] = 32'd3;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 2'b01) begin
            n_err++;
            $display("FAIL rstp_ptr: got %b want 01", req_ready);
        end
        next_cyc();
        req_valid = '0;
        @(negedge clk);
        n_vec++;
        if (active_div !== 32'd2) begin
            n_err++;
            $display("FAIL rstp_load: got %0d want 2", active_div);
        end
    endtask

    task automatic test_div1();
        logic [31:0] tc0;
        tc0 = '0;
        do_reset();
        req_valid = 2'b01;
        req_div[0] = 32'd1;
        @(negedge clk);
        next_cyc();
        req_valid = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_v = {2'b00, 1'b1, (k % 2 == 1), 1'b0, 32'd1};
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL div1_k%0d: got %h want %h", k, obs, exp_v);
            end
`ifdef DIV_SCHED_STAT_EN
            if (k == 0) tc0 = tick_count;
            if (k == 7) begin
                n_vec++;
                if (tick_count !== tc0 + 32'd7) begin
                    n_err++;
                    $display("FAIL tc_inc: got %h want %h", tick_count, tc0 + 32'd7);
                end
            end
`endif
        end
`ifdef DIV_SCHED_STAT_EN
        next_cyc();
        force dut.r_tick_count = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.r_tick_count;
        repeat (2) @(negedge clk);
        n_vec++;
        if (tick_count !== 32'd0) begin
            n_err++;
            $display("FAIL tc_wrap: got %h want 0", tick_count);
        end
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rr();
        test_pend();
        test_zero();
        test_reset_pend();
        test_div1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
- REQ-001 The module SHALL have parameter DIV_W, default 32, meaning the width of every divide value and of the period counter.
- REQ-002 The module SHALL have parameter NREQ, default 2, meaning the number of requesters sharing the divider.
- REQ-003 clk  input  1  the single clock; every flop SHALL be clocked on posedge clk.
- REQ-004 rst_n  input  1  asynchronous, active-low reset.
- REQ-005 req_valid  input  NREQ  per-requester request to load a new divide value.
- REQ-006 req_div  input  NREQ x DIV_W  per-requester divide value, valid while the matching req_valid is high.
- REQ-007 req_ready  output  NREQ  one-hot, one-cycle grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- REQ-008 tick  output  1  one-cycle pulse at every period boundary.
- REQ-009 new_clk  output  1  divided clock that toggles on each tick.
- REQ-010 busy  output  1  high while an accepted value is waiting to be applied.
- REQ-011 active_div  output  DIV_W  the divide value currently in force.

Function
- REQ-012 The FSM SHALL have three states: IDLE (divider stopped), RUN (counting), PEND (RUN with an accepted value held in pend_div).
- REQ-013 Arbitration SHALL be round-robin: the pointer is 0 after reset and moves to (granted index + 1) mod NREQ after each grant; requesters are searched starting at the pointer.
- REQ-014 req_ready SHALL be asserted only in IDLE or RUN, to at most one requester per cycle; in PEND all req_ready bits SHALL be 0 and requests are held off.
- REQ-015 Grant in IDLE: the next cycle SHALL load active_div from the granted req_div, set counter to 0, and enter RUN; the first tick SHALL follow active_div cycles later.
- REQ-016 In RUN and PEND, a boundary occurs when counter == active_div-1; on a boundary, tick=1 for that cycle, new_clk SHALL toggle, and counter SHALL return to 0; otherwise counter SHALL increment by 1.
- REQ-017 Grant in RUN: the accepted value SHALL be captured into pend_div and the FSM SHALL enter PEND with busy=1; the running period SHALL NOT be cut short.
- REQ-018 In PEND, at the boundary, active_div SHALL take pend_div and busy SHALL clear the next cycle.
- REQ-019 In PEND, if pend_div == 0 the FSM SHALL go to IDLE; otherwise it SHALL go to RUN.
- REQ-020 An accepted value of 0 in IDLE SHALL leave the FSM in IDLE.
- REQ-021 In IDLE: counter=0, tick=0, and new_clk=0. When entering IDLE from PEND, new_clk SHALL clear on the same edge that applies the 0 value.
- REQ-022 With active_div == 1, tick SHALL be high every cycle and new_clk SHALL toggle every cycle.
- REQ-023 Any grant to a requester whose req_valid is low SHALL be impossible.
- REQ-024 The counter compare SHALL be DIV_W wide and SHALL never wrap past active_div-1.

Reset
- REQ-025 On assertion of rst_n=0, the following SHALL clear asynchronously, including in the middle of a period or in PEND: state=IDLE, counter=0, active_div=0, pend_div=0, rr pointer=0, req_ready=0, tick=0, new_clk=0, busy=0.
- REQ-026 After reset is released, the block SHALL stay in IDLE until the first grant.

Configuration
- REQ-027 When DIV_SCHED_STAT_EN is defined, the block SHALL have an output tick_count of width 32 that increments on each tick, wraps from 0xFFFFFFFF to 0, and is 0 on reset.
- REQ-028 When DIV_SCHED_STAT_EN is undefined, the tick_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
- REQ-029 Package div_sched_pkg SHALL hold the state enum (S_IDLE, S_RUN, S_PEND), DIV_W_DEF, and NREQ_DEF.
- REQ-030 The round-robin arbiter SHALL be a separate sub-module rr_arb (inputs req, enable; outputs one-hot gnt; holds the pointer).

Verification
- REQ-031 Reset, then req_valid[0]=1 with div=3 -> req_ready[0] pulses once; first tick 3 cycles after the load; new_clk period is 6 cycles.
- REQ-032 Both requesters valid every cycle (div 2 and 4), with acceptance in IDLE/RUN -> grants alternate 0,1,0,1 starting at 0; no two-hot req_ready.
- REQ-033 RUN at div=5, request div=2 at counter=1 -> busy=1 until the boundary at counter=4; subsequent ticks every 2 cycles; no short period.
- REQ-034 RUN at div=4, request div=0 -> after the current boundary, state is IDLE, new_clk=0, and no further ticks occur.
- REQ-035 Assert rst_n in PEND at counter=2 -> all outputs are 0 immediately; after release, state is IDLE and the pending value is discarded.
- REQ-036 With DIV_SCHED_STAT_EN defined and div=1 -> tick_count increments every cycle; with the counter preset near 0xFFFFFFFF it wraps to 0.
